lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
Memory-access stage placed directly downstream of the core datapath. It consumes the ALU address, store data and size/sign code, and drives a multi-cycle data-memory bus with a req/ready handshake. It returns an aligned, sign- or zero-extended ReadData to the result mux, and stalls the pipeline while the bus is busy.

Parameters:
XLEN, 32, data and address width (only 32 is supported)
BE_W, 4, byte-enable width (XLEN/8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
MemRead  input  1  load request for the current instruction
MemWrite  input  1  store request for the current instruction
Funct3  input  3  access code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ALUResult  input  XLEN  byte address
WriteData  input  XLEN  store data (rs2)
ReadData  output  XLEN  extended load result, registered
Stall  output  1  freezes the upstream PC and pipeline registers
AccessErr  output  1  one-cycle pulse on a misaligned or illegal access
mem_req  output  1  bus request, registered
mem_we  output  1  1 = write
mem_addr  output  XLEN  word-aligned address ({ALUResult[31:2],2'b00})
mem_be  output  BE_W  byte enables
mem_wdata  output  XLEN  lane-replicated store data
mem_ready  input  1  bus completion; read data is valid in the same cycle
mem_rdata  input  XLEN  bus read data

Behaviour:
- FSM has three states: IDLE, BUSY, DONE. Reset forces IDLE.
- Reset values: ReadData=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, AccessErr=0. Stall=0 while reset is high.
- Access legality:
  - Illegal: MemRead and MemWrite both high; any store with Funct3 not in {000,001,010}; any load with Funct3 in {011,110,111}.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE with a legal, aligned access:
  - Latch mem_addr, mem_we, mem_be, mem_wdata, Funct3 and addr[1:0].
  - Go to BUSY; mem_req=1 from the next cycle.
  - Stall=1 combinationally in this same cycle.
- IDLE with an illegal or misaligned access:
  - No bus request; stay in IDLE.
  - AccessErr=1 for exactly one cycle, registered (asserts the cycle after detection).
  - Stall=0; ReadData unchanged.
- BUSY:
  - Stall=1. mem_req and all bus outputs are held stable until mem_ready=1.
  - On mem_ready: drop mem_req at the next edge, go to DONE.
  - For loads, register ReadData at that same edge.
- DONE:
  - Lasts one cycle with Stall=0, so the instruction retires.
  - MemRead/MemWrite are ignored here (they still reflect the retiring instruction), which prevents a double issue.
  - Then go to IDLE.
- Latency: a bus that answers with mem_ready in its first req cycle gives 3 cycles from acceptance to retirement; each wait cycle adds one.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
  - Loads also drive mem_be the same way; mem_we=0.
- Store data:
  - Byte: {4{WriteData[7:0]}}.
  - Half: {2{WriteData[15:0]}}.
  - Word: WriteData.
- Load extraction:
  - lane = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- ReadData holds its value until the next completed load; stores do not modify it.
- A mem_ready outside BUSY is ignored.
- Reset in BUSY abandons the transaction: mem_req=0 after the edge, no DONE, ReadData=0.

Decomposition:
- Shared package holds:
  - Funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state encoding (IDLE, BUSY, DONE)
  - XLEN/BE_W constants
- One sub-module, lsu_align: combinational legality check, byte-enable, store-lane replication and load extraction/extension. The top level holds the FSM and registers.

Test Plan:
- LW at 0x100, mem_ready after 2 wait cycles, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, Stall high 4 cycles, ReadData=0xDEADBEEF in DONE.
- LB at 0x103, mem_rdata=0x80112233 -> mem_be=1000, ReadData=0xFFFFFF80; the same access as LBU gives 0x00000080.
- SH at 0x102 with WriteData=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; ReadData unchanged.
- LW at 0x101, then MemRead=MemWrite=1 -> AccessErr one-cycle pulse each, mem_req never asserted, Stall=0.
- Reset asserted in the 2nd BUSY cycle of an LW -> mem_req=0 after the edge, state IDLE, ReadData=0; a later mem_ready is ignored.
- Back-to-back: SW 0x200 then LHU 0x202 with zero-wait bus -> exactly one request per instruction, no re-issue in DONE, LHU result 0x0000xxxx from the upper half-lane.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared constants for the load/store memory stage: widths, access codes, FSM states.
package lsu_mem_stage_pkg;

  localparam int unsigned LSU_XLEN = 32;
  localparam int unsigned LSU_BE_W = LSU_XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational access checks, byte enables, store-lane replication and load extension.
module lsu_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN,
  parameter int unsigned BE_W = LSU_BE_W
) (
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      req_funct3,
  input  logic [1:0]      req_addr_lo,
  input  logic [XLEN-1:0] write_data,
  output logic            illegal,
  output logic            misaligned,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  input  logic [2:0]      rsp_funct3,
  input  logic [1:0]      rsp_addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_write) begin
      illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else if (mem_read) begin
      illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
  end

  // Size is encoded in funct3[1:0]; the unsigned bit does not affect alignment or lanes.
  always_comb begin
    misaligned = 1'b0;
    be         = '1;
    wdata      = write_data;
    unique case (req_funct3[1:0])
      2'b00: begin
        be    = BE_W'(4'b0001) << req_addr_lo;
        wdata = {(XLEN/8){write_data[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_lo[0];
        be         = BE_W'(4'b0011) << {req_addr_lo[1], 1'b0};
        wdata      = {(XLEN/16){write_data[15:0]}};
      end
      2'b10: begin
        misaligned = (req_addr_lo != 2'b00);
      end
      default: begin
        misaligned = 1'b0;
      end
    endcase
  end

  always_comb begin
    lane = rdata >> {rsp_addr_lo, 3'b000};
    unique case (rsp_funct3)
      F3_B:    load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: issues one bus transaction per load/store and stalls the pipeline until it completes.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN,
  parameter int unsigned BE_W = LSU_BE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Stall,
  output logic            AccessErr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] read_data_q, read_data_d;
  logic            access_err_q, access_err_d;

  logic            illegal, misaligned;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, load_data_c;
  logic            stall_c;

  lsu_align #(
    .XLEN (XLEN),
    .BE_W (BE_W)
  ) u_align (
    .mem_read    (MemRead),
    .mem_write   (MemWrite),
    .req_funct3  (Funct3),
    .req_addr_lo (ALUResult[1:0]),
    .write_data  (WriteData),
    .illegal     (illegal),
    .misaligned  (misaligned),
    .be          (be_c),
    .wdata       (wdata_c),
    .rsp_funct3  (funct3_q),
    .rsp_addr_lo (addr_lo_q),
    .rdata       (mem_rdata),
    .load_data   (load_data_c)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    read_data_d  = read_data_q;
    access_err_d = 1'b0;
    stall_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (!illegal && !misaligned) begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = {ALUResult[XLEN-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            funct3_d    = Funct3;
            addr_lo_d   = ALUResult[1:0];
            stall_c     = 1'b1;
          end else begin
            access_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            read_data_d = load_data_c;
          end
        end
      end
      // The retiring instruction is still on the inputs here, so they must not be re-decoded.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      read_data_q  <= '0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      read_data_q  <= read_data_d;
      access_err_q <= access_err_d;
    end
  end

  assign Stall     = stall_c && !reset;
  assign ReadData  = read_data_q;
  assign AccessErr = access_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
